prog_interval_timer: RTL and testbench
======================================

// Module: prog_interval_timer
// PURPOSE
//  Parametrised successor to the fixed one-second timer: prescaler + programmable interval down-counter.
//  Generates a base tick every PRE_DIV clocks and an expiry pulse after a loaded number of ticks.
//  Supports one-shot or periodic mode, pause (hold), and on-the-fly reload.
//  Sits between the system clock and control FSMs that need second-scale or programmable timeouts.
// PARAMETERS
//  PRE_DIV  50_000_000  clocks per base tick (>=2); simulation benches use 4
//  PRE_W    26          prescaler width; must hold PRE_DIV-1
//  CNT_W    16          interval counter width; max interval 2^CNT_W-1 ticks
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous active-low reset
//  enable     in   1      run request; low forces IDLE and clears counters
//  load       in   1      1-cycle strobe: latch load_val and (re)start interval
//  load_val   in   CNT_W  interval length in base ticks; 0 is rejected
//  periodic   in   1      1 = auto-reload at expiry, 0 = one-shot
//  hold       in   1      1 = freeze prescaler and interval counter (pause)
//  tick_out   out  1      1-cycle pulse per base tick while RUN
//  expire     out  1      1-cycle pulse when interval reaches zero
//  remaining  out  CNT_W  ticks left in current interval
//  busy       out  1      high in RUN
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; prescaler=0; remaining=0; interval reg=0;
//   tick_out=0, expire=0, busy=0. Reset overrides every other input.
//  All outputs registered. tick_out/expire are single-cycle pulses, never held.
//  States: IDLE, RUN, DONE (2-bit encoding; unused code -> IDLE next cycle).
//  IDLE: prescaler=0, remaining=0. If enable=1 & load=1 & load_val!=0: latch
//   interval=remaining=load_val, go RUN. load with load_val==0 ignored (stay IDLE).
//   enable=1 without load stays IDLE.
//  RUN: busy=1. If enable=0 -> IDLE next cycle, counters cleared, no pulses (highest priority).
//   Else if load=1 & load_val!=0: interval=remaining=load_val, prescaler=0, no pulse this cycle.
//   Else if load=1 & load_val==0: ignored; counting continues as if load=0.
//   Else if hold=1: all counters frozen, no pulses.
//   Else prescaler increments; at PRE_DIV-1 it wraps to 0 and tick_out pulses next cycle;
//   on that wrap remaining decrements. When remaining==1 at wrap: expire and tick_out pulse together;
//   periodic=1 -> remaining=interval, stay RUN; periodic=0 -> remaining=0, go DONE.
//  DONE: busy=0, remaining=0. enable=0 -> IDLE. load=1 & load_val!=0 (enable=1) -> RUN with new value.
//  Timing: load accepted at edge E -> first expire high in cycle after edge E+N*PRE_DIV
//   (N=load_val), plus one cycle per hold cycle. Periodic expiries every N*PRE_DIV cycles.
//  periodic sampled only at the expiry wrap; changing it mid-interval is legal.
//  remaining never underflows; wrap-around only via reload. Prescaler never exceeds PRE_DIV-1.
//  Reset mid-RUN: state and outputs return to reset values on that edge; any pulse in flight is dropped.
// TESTING (PRE_DIV=4, CNT_W=8)
//  Reset: drive rst=0 for 2 cycles with enable=1, load=1 -> all outputs 0, busy=0.
//  One-shot: load_val=3, periodic=0 -> tick_out at +4,+8,+12; expire with 3rd tick; DONE, busy=0, remaining=0.
//  Periodic: load_val=2, periodic=1 -> expire every 8 cycles for 5 periods; remaining goes 2,1,2,1...
//  Hold: load_val=1, hold high for 3 cycles mid-count -> expire delayed from cycle 4 to cycle 7.
//  Reload: at remaining=5 of 10, load load_val=2 -> prescaler restarts; expire 8 cycles later.
//  Abort/zero: enable=0 in the same cycle as the expiry wrap -> no expire, IDLE; load_val=0 -> stays IDLE.

Source files
------------

// File: rtl/prog_interval_timer.sv
// rtl/prog_interval_timer.sv - prescaled programmable interval timer (one-shot/periodic, hold, reload)
// A base tick every PRE_DIV clocks drives an interval down-counter that pulses expire at zero.
module prog_interval_timer #(
    parameter int PRE_DIV = 50_000_000,
    parameter int PRE_W   = 26,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             periodic_i,
    input  logic             hold_i,
    output logic             tick_out_o,
    output logic             expire_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             tick_q, tick_d;
    logic             expire_q, expire_d;
    logic             busy_q, busy_d;

    logic load_ok;
    logic wrap;

    assign load_ok = load_i && (load_val_i != '0);
    assign wrap    = (presc_q == PRE_W'(PRE_DIV - 1));

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        interval_d  = interval_q;
        tick_d      = 1'b0;
        expire_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                presc_d     = '0;
                remaining_d = '0;
                if (enable_i && load_ok) begin
                    interval_d  = load_val_i;
                    remaining_d = load_val_i;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable_i) begin
                    presc_d     = '0;
                    remaining_d = '0;
                    state_d     = S_IDLE;
                end else if (load_ok) begin
                    interval_d  = load_val_i;
                    remaining_d = load_val_i;
                    presc_d     = '0;
                end else if (hold_i) begin
                    presc_d = presc_q;
                end else if (wrap) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    // <=1 rather than ==1 so a zero count can never underflow
                    if (remaining_q <= CNT_W'(1)) begin
                        expire_d = 1'b1;
                        if (periodic_i) begin
                            remaining_d = interval_q;
                        end else begin
                            remaining_d = '0;
                            state_d     = S_DONE;
                        end
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            S_DONE: begin
                presc_d     = '0;
                remaining_d = '0;
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (load_ok) begin
                    interval_d  = load_val_i;
                    remaining_d = load_val_i;
                    state_d     = S_RUN;
                end
            end
            default: begin
                presc_d     = '0;
                remaining_d = '0;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
            interval_q  <= '0;
            tick_q      <= 1'b0;
            expire_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            interval_q  <= interval_d;
            tick_q      <= tick_d;
            expire_q    <= expire_d;
            busy_q      <= busy_d;
        end
    end

    assign tick_out_o  = tick_q;
    assign expire_o    = expire_q;
    assign remaining_o = remaining_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// tb/tb_prog_interval_timer.sv - scoreboard bench for prog_interval_timer (PRE_DIV=4, CNT_W=8)
// Stimulus pushes expected pulse events; a negedge monitor pops them whenever tick/expire fires.
module tb_prog_interval_timer;

    localparam int PRE_DIV = 4;
    localparam int PRE_W   = 3;
    localparam int CNT_W   = 8;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             periodic;
    logic             hold;
    logic             tick_out;
    logic             expire;
    logic [CNT_W-1:0] remaining;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int cyc;
        bit exp;
        int rem;
    } ev_t;

    ev_t sb[$];

    prog_interval_timer #(
        .PRE_DIV(PRE_DIV),
        .PRE_W  (PRE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .load_i     (load),
        .load_val_i (load_val),
        .periodic_i (periodic),
        .hold_i     (hold),
        .tick_out_o (tick_out),
        .expire_o   (expire),
        .remaining_o(remaining),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b1 && (tick_out !== 1'b0 || expire !== 1'b0)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d tick=%0b expire=%0b rem=%0d, expected no pulse",
                         cyc, tick_out, expire, remaining);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || tick_out !== 1'b1 || expire !== e.exp || remaining !== CNT_W'(e.rem)) begin
                    miscompares++;
                    $display("FAIL pulse_event got cyc=%0d tick=%0b expire=%0b rem=%0d, expected cyc=%0d tick=1 expire=%0b rem=%0d",
                             cyc, tick_out, expire, remaining, e.cyc, e.exp, e.rem);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input bit e, input int r);
        ev_t ev;
        ev.cyc = c;
        ev.exp = e;
        ev.rem = r;
        sb.push_back(ev);
    endtask

    // Inputs change only at negedges; the next posedge is edge cyc+1.
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit ld, input int val, input bit per, input bit hld);
        enable   = en;
        load     = ld;
        load_val = CNT_W'(val);
        periodic = per;
        hold     = hld;
    endtask

    int e0;
    int e1;

    initial begin
        rst = 1'b0;
        drive(1, 1, 5, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("reset_tick", {31'b0, tick_out}, 0);
        check("reset_expire", {31'b0, expire}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_remaining", {24'b0, remaining}, 0);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("idle_no_load_busy", {31'b0, busy}, 0);

        // one-shot, 3 ticks
        drive(1, 1, 3, 0, 0);
        e0 = cyc + 1;
        push(e0 + 4, 0, 2);
        push(e0 + 8, 0, 1);
        push(e0 + 12, 1, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        check("oneshot_busy_after_load", {31'b0, busy}, 1);
        check("oneshot_remaining_after_load", {24'b0, remaining}, 3);
        wait_to(e0 + 14);
        check("oneshot_done_busy", {31'b0, busy}, 0);
        check("oneshot_done_remaining", {24'b0, remaining}, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        // periodic, 2 ticks per period, 5 periods
        drive(1, 1, 2, 1, 0);
        e0 = cyc + 1;
        for (int k = 1; k <= 10; k++) push(e0 + 4 * k, (k % 2) == 0, ((k % 2) == 0) ? 2 : 1);
        @(negedge clk);
        drive(1, 0, 0, 1, 0);
        wait_to(e0 + 40);
        check("periodic_busy_after_5", {31'b0, busy}, 1);
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        check("periodic_stop_busy", {31'b0, busy}, 0);

        // hold for 3 cycles delays a 1-tick expiry from +4 to +7
        drive(1, 1, 1, 0, 0);
        e0 = cyc + 1;
        push(e0 + 7, 1, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        wait_to(e0 + 2);
        drive(1, 0, 0, 0, 1);
        wait_to(e0 + 5);
        drive(1, 0, 0, 0, 0);
        wait_to(e0 + 9);
        check("hold_done_busy", {31'b0, busy}, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        // reload 2 when 5 of 10 remain; a zero load first must be ignored
        drive(1, 1, 10, 0, 0);
        e0 = cyc + 1;
        for (int k = 1; k <= 5; k++) push(e0 + 4 * k, 0, 10 - k);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        wait_to(e0 + 21);
        check("reload_remaining_before", {24'b0, remaining}, 5);
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 2, 0, 0);
        e1 = cyc + 1;
        push(e1 + 4, 0, 1);
        push(e1 + 8, 1, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        check("reload_remaining_after", {24'b0, remaining}, 2);
        wait_to(e1 + 10);
        check("reload_done_busy", {31'b0, busy}, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        // abort on the expiry wrap edge: no pulse, back to IDLE
        drive(1, 1, 1, 1, 0);
        e0 = cyc + 1;
        @(negedge clk);
        drive(1, 0, 0, 1, 0);
        wait_to(e0 + 3);
        drive(0, 0, 0, 1, 0);
        wait_to(e0 + 6);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_remaining", {24'b0, remaining}, 0);

        // zero load from IDLE is rejected
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check("zero_load_busy", {31'b0, busy}, 0);
        check("zero_load_remaining", {24'b0, remaining}, 0);
        repeat (10) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
